// File: rtl/adder_ctrl_pkg.sv
// adder_ctrl_pkg
//   Shared definitions for the serial add controller: the controller state
//   encoding and the width of one adder pass (one nibble).
package adder_ctrl_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : adder_ctrl_pkg

// File: rtl/ripple_carry_adder.sv
// ripple_carry_adder
//   Purely combinational NIBBLE_W-bit ripple-carry adder. It is the only
//   adder in the serial add controller and is reused once per pass.
// Ports:
//   a, b  : NIBBLE_W-bit addends
//   cin   : carry in
//   sum   : NIBBLE_W-bit sum
//   carry : carry out of the MSB
module ripple_carry_adder
   import adder_ctrl_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                cin,
   output logic [NIBBLE_W-1:0] sum,
   output logic                carry
);

   // c[i] is the carry into bit i; c[NIBBLE_W] is the carry out.
   logic [NIBBLE_W:0] c;

   assign c[0] = cin;

   genvar gi;
   generate
      for (gi = 0; gi < NIBBLE_W; gi++) begin : g_bit
         assign sum[gi]  = a[gi] ^ b[gi] ^ c[gi];
         assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
      end
   endgenerate

   assign carry = c[NIBBLE_W];

endmodule : ripple_carry_adder

// File: rtl/serial_add_controller.sv
// serial_add_controller
//   Adds (or subtracts) two W-bit operands one nibble per clock using a
//   single 4-bit ripple-carry adder, least significant nibble first.
//   Valid/ready handshake on both the request and the result side.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   in_valid/ready : request handshake (in_ready high only while idle)
//   a, b, cin, sub : operands, carry-in, subtract select (sampled on accept)
//   out_valid/ready: result handshake
//   sum, cout      : W-bit result and carry out of the MSB nibble
//   overflow       : two's-complement signed overflow
module serial_add_controller
   import adder_ctrl_pkg::*;
#(
   parameter int NIBBLES = 4
)
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [NIBBLE_W*NIBBLES-1:0] a,
   input  logic [NIBBLE_W*NIBBLES-1:0] b,
   input  logic                      cin,
   input  logic                      sub,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [NIBBLE_W*NIBBLES-1:0] sum,
   output logic                      cout,
   output logic                      overflow
);

   localparam int W     = NIBBLE_W * NIBBLES;
   localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   state_t            state_reg;
   logic [IDX_W-1:0]  idx_reg;
   logic [W-1:0]      a_reg;
   logic [W-1:0]      b_reg;      // already inverted for subtraction
   logic              carry_reg;

   logic [NIBBLE_W-1:0] add_a;
   logic [NIBBLE_W-1:0] add_b;
   logic [NIBBLE_W-1:0] add_sum;
   logic                add_carry;

   assign add_a = a_reg[idx_reg*NIBBLE_W +: NIBBLE_W];
   assign add_b = b_reg[idx_reg*NIBBLE_W +: NIBBLE_W];

   ripple_carry_adder u_adder (
      .a     (add_a),
      .b     (add_b),
      .cin   (carry_reg),
      .sum   (add_sum),
      .carry (add_carry)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         idx_reg   <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         carry_reg <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         overflow  <= 1'b0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  a_reg     <= a;
                  // Subtraction is a + ~b + 1, so cin is irrelevant then.
                  b_reg     <= sub ? ~b : b;
                  carry_reg <= sub ? 1'b1 : cin;
                  idx_reg   <= '0;
                  in_ready  <= 1'b0;
                  state_reg <= RUN;
               end
            end
            RUN: begin
               sum[idx_reg*NIBBLE_W +: NIBBLE_W] <= add_sum;
               carry_reg <= add_carry;
               idx_reg   <= idx_reg + 1'b1;
               if (idx_reg == LAST_IDX) begin
                  idx_reg   <= '0;
                  cout      <= add_carry;
                  // add_sum MSB is the final sum MSB on the last pass.
                  overflow  <= (a_reg[W-1] == b_reg[W-1]) &&
                               (add_sum[NIBBLE_W-1] != a_reg[W-1]);
                  out_valid <= 1'b1;
                  state_reg <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state_reg <= IDLE;
               end
            end
            default: begin
               state_reg <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule : serial_add_controller

// File: tb/tb_serial_add_controller.sv
// tb_serial_add_controller
//   Directed, table-driven bench for serial_add_controller (NIBBLES = 4),
//   plus hand-written sequences for result hold, mid-run reset and
//   ignored requests while busy.
module tb_serial_add_controller;

   localparam int NIBBLES = 4;
   localparam int W       = 4 * NIBBLES;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          cin;
   logic          sub;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  sum;
   logic          cout;
   logic          overflow;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   serial_add_controller #(.NIBBLES(NIBBLES)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .overflow  (overflow)
   );

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         sub;
      logic [W-1:0] exp_sum;
      logic         exp_cout;
      logic         exp_ovf;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Runs one operation. hold: cycles to keep out_ready low in DONE.
   // noise: wiggle in_valid and the operand inputs while the op is running.
   task automatic do_op(input vec_t v, input int hold, input bit noise);
      int cnt;
      logic [W-1:0] held_sum;
      cnt = 0;
      @(negedge clk);
      while (!in_ready && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      chk("in_ready_before_accept", 32'(in_ready), 32'd1);
      chk("out_valid_while_idle", 32'(out_valid), 32'd0);
      a = v.a; b = v.b; cin = v.cin; sub = v.sub; in_valid = 1'b1;
      @(posedge clk);  // accept edge
      @(negedge clk);
      in_valid = 1'b0;
      cnt = 0;
      while (!out_valid && cnt < 20) begin
         if (noise) begin
            in_valid = ~in_valid;
            a = 16'($urandom);
            b = 16'($urandom);
            cin = 1'($urandom);
            sub = 1'($urandom);
         end
         chk("in_ready_busy", 32'(in_ready), 32'd0);
         @(negedge clk);
         cnt++;
      end
      in_valid = 1'b0;
      chk("latency", 32'(cnt), 32'(NIBBLES));
      chk("sum", 32'(sum), 32'(v.exp_sum));
      chk("cout", 32'(cout), 32'(v.exp_cout));
      chk("overflow", 32'(overflow), 32'(v.exp_ovf));
      chk("in_ready_done", 32'(in_ready), 32'd0);
      held_sum = sum;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("hold_out_valid", 32'(out_valid), 32'd1);
         chk("hold_sum", 32'(sum), 32'(held_sum));
         chk("hold_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("out_valid_after_ack", 32'(out_valid), 32'd0);
      chk("in_ready_after_ack", 32'(in_ready), 32'd1);
      $display("op a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d ovf=%0d lat=%0d",
               v.a, v.b, v.cin, v.sub, held_sum, v.exp_cout, v.exp_ovf, cnt);
   endtask

   initial begin
      vec_t v;
      vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
      vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
      vecs[5] = '{16'h00FF, 16'h0F01, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0};
      vecs[6] = '{16'h0010, 16'h0010, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
      vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
      vecs[8] = '{16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0, 1'b0};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_sum", 32'(sum), 32'd0);
      chk("reset_cout", 32'(cout), 32'd0);
      chk("reset_overflow", 32'(overflow), 32'd0);

      for (int i = 0; i < 9; i++) do_op(vecs[i], 0, 1'b0);

      // Result must hold while the consumer stalls for 3 cycles.
      do_op(vecs[4], 3, 1'b0);

      // Requests during RUN/DONE must be ignored.
      v = '{16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0};
      do_op(v, 0, 1'b1);

      // Reset sampled on the 2nd RUN cycle aborts the operation.
      @(negedge clk);
      a = 16'h7FFF; b = 16'h7FFF; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk);            // accept
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);            // 1st RUN cycle
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);            // 2nd RUN cycle, reset wins
      @(negedge clk);
      rst = 1'b0;
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_sum", 32'(sum), 32'd0);
      chk("abort_cout", 32'(cout), 32'd0);
      chk("abort_overflow", 32'(overflow), 32'd0);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("abort_no_out_valid", 32'(out_valid), 32'd0);
      end
      $display("abort sequence checked");

      do_op(vecs[0], 0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_serial_add_controller
